sdc_reg_arbiter: RTL and testbench

SDC_REG_ARBITER -- requirements
Module: sdc_reg_arbiter

---
 rtl/sdc_reg_arbiter_if.sv | 22 ++
 rtl/sdc_reg_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sdc_reg_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_reg_arbiter_if.sv
// rtl/sdc_reg_arbiter_if.sv - register-port bus shared by the SD register arbiter masters and controller
// One instance per port: master drives the request, slave returns readdata and the completion strobe.
interface sdc_reg_arbiter_if;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;
  logic        waitrequest_n;

  modport master (
    output address, writedata, byteenable, write, read, chipselect,
    input  readdata, waitrequest_n
  );

  modport slave (
    input  address, writedata, byteenable, write, read, chipselect,
    output readdata, waitrequest_n
  );
endinterface

// File: rtl/sdc_reg_arbiter.sv
// rtl/sdc_reg_arbiter.sv - two-master round-robin arbiter onto the SD controller register port
// Optional watchdog on a stalled controller is built when SDC_ARB_TIMEOUT_EN is defined.
module sdc_reg_arbiter (
  input  logic              clk_i,
  input  logic              rst_i,
  sdc_reg_arbiter_if.slave  m0,
  sdc_reg_arbiter_if.slave  m1,
  sdc_reg_arbiter_if.master s,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        strobe0_q, strobe0_d;
  logic        strobe1_q, strobe1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        req0, req1, pick_m1, ack, tmo_fire, done;
  logic [31:0] done_data;

  assign req0 = m0.chipselect & (m0.read | m0.write);
  assign req1 = m1.chipselect & (m1.read | m1.write);
  assign ack  = s.waitrequest_n;
  // owner_q doubles as the round-robin pointer: it still names the last winner while idle
  assign pick_m1 = req1 & (~req0 | ~owner_q);
  assign done = (state_q == BUSY) & (ack | tmo_fire);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      strobe0_q <= 1'b0;
      strobe1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      strobe0_q <= strobe0_d;
      strobe1_q <= strobe1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 | req1) state_d = BUSY;
      BUSY:    if (ack | tmo_fire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    strobe0_d = 1'b0;
    strobe1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    done_data = ack ? (rd_q ? s.readdata : 32'h0) : 32'hDEADBEEF;

    if (state_q == IDLE && (req0 | req1)) begin
      owner_d = pick_m1;
      // read wins when a master sets both qualifiers
      if (pick_m1) begin
        addr_d  = m1.address;
        wdata_d = m1.writedata;
        be_d    = m1.byteenable;
        rd_d    = m1.read;
        wr_d    = m1.write & ~m1.read;
      end else begin
        addr_d  = m0.address;
        wdata_d = m0.writedata;
        be_d    = m0.byteenable;
        rd_d    = m0.read;
        wr_d    = m0.write & ~m0.read;
      end
    end

    if (done) begin
      if (owner_q) begin
        strobe1_d = 1'b1;
        rdata1_d  = done_data;
      end else begin
        strobe0_d = 1'b1;
        rdata0_d  = done_data;
      end
    end
  end

  always_comb begin
    s.chipselect    = (state_q == BUSY);
    s.read          = (state_q == BUSY) & rd_q;
    s.write         = (state_q == BUSY) & wr_q;
    s.address       = addr_q;
    s.writedata     = wdata_q;
    s.byteenable    = be_q;
    grant_o         = (state_q == BUSY) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    m0.waitrequest_n = strobe0_q;
    m0.readdata      = rdata0_q;
    m1.waitrequest_n = strobe1_q;
    m1.readdata      = rdata1_q;
  end

`ifdef SDC_ARB_TIMEOUT_EN
  logic [7:0] count_q, count_d;
  logic       timeout_q, timeout_d;

  // an ack landing on the final count takes precedence over the watchdog
  assign tmo_fire  = (state_q == BUSY) & (count_q == 8'hFF) & ~ack;
  assign timeout_o = timeout_q;

  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q | tmo_fire;
    if (state_q != BUSY) count_d = '0;
    else if (count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdc_reg_arbiter.sv
// tb/tb_sdc_reg_arbiter.sv - scoreboard bench for sdc_reg_arbiter
// Directed stimulus pushes expected strobes; a negedge monitor pops and compares them.
module tb_sdc_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       tmo;

  always #5 clk = ~clk;

  sdc_reg_arbiter_if m0_if ();
  sdc_reg_arbiter_if m1_if ();
  sdc_reg_arbiter_if s_if ();

  sdc_reg_arbiter dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ack_delay = 1;
  bit          ack_en = 1'b1;
  logic [31:0] rsp_data = 32'h0;
  int          acnt = 0;
  int          rem0 = 0;
  int          rem1 = 0;
  bit          b2b_chk = 1'b0;
  bit          have_strobe = 1'b0;
  int          strobe_cyc = 0;
  logic        cs_prev = 1'b0;
  int          t_cs, t_st, n_strobe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_m(input bit which, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (!which) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = d; m0_if.byteenable = be; m0_if.chipselect = 1'b1;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = d; m1_if.byteenable = be; m1_if.chipselect = 1'b1;
    end
  endtask

  task automatic serve(input int budget);
    int n = 0;
    while ((rem0 > 0 || rem1 > 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (m0_if.waitrequest_n && rem0 > 0) begin
        rem0--;
        if (rem0 == 0) m0_if.chipselect = 1'b0;
      end
      if (m1_if.waitrequest_n && rem1 > 0) begin
        rem1--;
        if (rem1 == 0) m1_if.chipselect = 1'b0;
      end
    end
    chk("serve_outstanding", rem0 + rem1, 0);
    rem0 = 0; rem1 = 0;
    m0_if.chipselect = 1'b0; m1_if.chipselect = 1'b0;
  endtask

  // controller model: ack on the ack_delay-th chipselect cycle, garbage readdata otherwise
  initial begin
    s_if.waitrequest_n = 1'b0;
    s_if.readdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      s_if.waitrequest_n = 1'b0;
      s_if.readdata = 32'hBAD0BAD0;
      if (s_if.chipselect && ack_en) begin
        acnt++;
        if (acnt == ack_delay) begin
          s_if.waitrequest_n = 1'b1;
          s_if.readdata = rsp_data + {24'h0, s_if.address};
        end
      end else begin
        acnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m0_if.waitrequest_n || m1_if.waitrequest_n) begin
        strobe_cyc = cyc;
        if (b2b_chk) have_strobe = 1'b1;
        if (m0_if.waitrequest_n && m1_if.waitrequest_n) begin
          tests++; fails++;
          $display("FAIL dual_strobe: both masters strobed at cycle %0d, required one", cyc);
        end else if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: strobe m%0d at cycle %0d, required none", m1_if.waitrequest_n, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_owner", {31'h0, m1_if.waitrequest_n}, {31'h0, mon_e.id});
          chk("readdata", m1_if.waitrequest_n ? m1_if.readdata : m0_if.readdata, mon_e.data);
        end
      end
      if (!b2b_chk) have_strobe = 1'b0;
      if (s_if.chipselect && !cs_prev && b2b_chk && have_strobe)
        chk("b2b_gap", cyc - strobe_cyc, 2);
      cs_prev = s_if.chipselect;
    end
  end

  initial begin
    m0_if.chipselect = 0; m0_if.read = 0; m0_if.write = 0;
    m0_if.address = 0; m0_if.writedata = 0; m0_if.byteenable = 0;
    m1_if.chipselect = 0; m1_if.read = 0; m1_if.write = 0;
    m1_if.address = 0; m1_if.writedata = 0; m1_if.byteenable = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", s_if.chipselect, 0);
    chk("rst_rdwr", {s_if.read, s_if.write}, 0);
    chk("rst_grant", grant, 0);
    chk("rst_strobes", {m0_if.waitrequest_n, m1_if.waitrequest_n}, 0);
    chk("rst_rdata", m0_if.readdata | m1_if.readdata, 0);
    chk("rst_timeout", tmo, 0);
    rst = 1'b0;

    // simultaneous requesters alternate starting with m0, two-cycle spacing
    ack_delay = 1; rsp_data = 32'hAAAA0000;
    push(0, 32'hAAAA0020); push(1, 32'hAAAA0030);
    push(0, 32'hAAAA0020); push(1, 32'hAAAA0030);
    @(negedge clk);
    rem0 = 2; rem1 = 2; b2b_chk = 1'b1;
    set_m(0, 1, 0, 8'h20, 32'h0, 4'hF);
    set_m(1, 1, 0, 8'h30, 32'h0, 4'hF);
    serve(200);
    b2b_chk = 1'b0;
    repeat (2) @(negedge clk);

    // single m0 read, ack on fourth busy cycle
    ack_delay = 4; rsp_data = 32'h12345674;
    push(0, 32'h12345678);
    set_m(0, 1, 0, 8'h04, 32'h0, 4'hF);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk($sformatf("rd_cs_c%0d", i), s_if.chipselect, (i <= 4) ? 1 : 0);
      chk($sformatf("rd_grant_c%0d", i), grant, (i <= 4) ? 2'b01 : 2'b00);
      chk($sformatf("rd_strobe_c%0d", i), m0_if.waitrequest_n, (i == 5) ? 1 : 0);
      if (i <= 4) chk($sformatf("rd_addr_c%0d", i), {s_if.read, s_if.write, s_if.address}, {2'b10, 8'h04});
      if (m0_if.waitrequest_n) m0_if.chipselect = 1'b0;
    end
    m0_if.chipselect = 1'b0;

    // m1 write whose inputs change while busy
    ack_delay = 5;
    push(1, 32'h0);
    set_m(1, 0, 1, 8'h10, 32'hA5A5A5A5, 4'hC);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 5) begin
        chk($sformatf("wr_data_c%0d", i), s_if.writedata, 32'hA5A5A5A5);
        chk($sformatf("wr_ctl_c%0d", i), {s_if.byteenable, s_if.read, s_if.write, s_if.address},
            {4'hC, 2'b01, 8'h10});
        chk($sformatf("wr_grant_c%0d", i), grant, 2'b10);
      end
      if (i == 2) begin
        m1_if.writedata = 32'h5A5A5A5A;
        m1_if.byteenable = 4'h3;
      end
      if (i == 6) chk("nonowner_hold", {m0_if.waitrequest_n, m0_if.readdata}, {1'b0, 32'h12345678});
      if (m1_if.waitrequest_n) m1_if.chipselect = 1'b0;
    end
    m1_if.chipselect = 1'b0;
    repeat (2) @(negedge clk);

    // read and write both set forwards as a read
    ack_delay = 2; rsp_data = 32'h00005000;
    push(0, 32'h00005008);
    rem0 = 1;
    set_m(0, 1, 1, 8'h08, 32'h11111111, 4'hF);
    @(negedge clk);
    chk("rw_as_read", {s_if.chipselect, s_if.read, s_if.write}, 3'b110);
    serve(20);
    repeat (2) @(negedge clk);

    // reset during the second busy cycle abandons the transfer
    ack_en = 1'b0;
    set_m(0, 1, 0, 8'h44, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_s_ctl", {s_if.chipselect, s_if.read, s_if.write, s_if.address, s_if.byteenable}, 0);
    chk("abort_grant", grant, 0);
    chk("abort_strobes", {m0_if.waitrequest_n, m1_if.waitrequest_n}, 0);
    chk("abort_rdata", m0_if.readdata | m1_if.readdata, 0);
    m0_if.chipselect = 1'b0;
    rst = 1'b0;
    ack_en = 1'b1; ack_delay = 1; rsp_data = 32'h0;
    push(0, 32'h00000050); push(1, 32'h00000060);
    @(negedge clk);
    rem0 = 1; rem1 = 1;
    set_m(0, 1, 0, 8'h50, 32'h0, 4'hF);
    set_m(1, 1, 0, 8'h60, 32'h0, 4'hF);
    @(negedge clk);
    chk("post_rst_grant", grant, 2'b01);
    serve(50);
    repeat (2) @(negedge clk);

    // controller never acks
    ack_en = 1'b0;
    set_m(0, 1, 0, 8'h70, 32'h0, 4'hF);
`ifdef SDC_ARB_TIMEOUT_EN
    push(0, 32'hDEADBEEF);
    t_cs = -1; t_st = -1;
    for (int i = 0; i < 400 && t_st < 0; i++) begin
      @(negedge clk);
      if (s_if.chipselect && t_cs < 0) t_cs = cyc;
      if (m0_if.waitrequest_n) t_st = cyc;
    end
    m0_if.chipselect = 1'b0;
    chk("tmo_latency", t_st - t_cs, 256);
    @(negedge clk);
    chk("tmo_flag", tmo, 1);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", {tmo, s_if.chipselect}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("tmo_rst_clear", tmo, 0);
    rst = 1'b0;
`else
    n_strobe = 0;
    repeat (1000) begin
      @(negedge clk);
      if (m0_if.waitrequest_n) n_strobe++;
    end
    chk("no_tmo_strobes", n_strobe, 0);
    chk("no_tmo_flag", tmo, 0);
    chk("no_tmo_busy", s_if.chipselect, 1);
    rst = 1'b1;
    @(negedge clk);
    m0_if.chipselect = 1'b0;
    rst = 1'b0;
`endif
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
